// File: rtl/add8_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// State encoding, adder width and the rotating-priority pick function.
package add8_sched_pkg;

    localparam int ADD_WIDTH = 8;
    localparam int MAX_REQ   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scanned from the far end so the requester nearest to ptr wins by last assignment.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [3:0]         ptr,
                                      input int                 num_req);
        pick_t res;
        int    j;
        res = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < num_req) begin
                j = int'(ptr) + i;
                if (j >= num_req) j = j - num_req;
                if (valid[j]) begin
                    res.found = 1'b1;
                    res.idx   = 4'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add8_rr_sched_core.sv
// Combinational ripple adder built from XOR/AND stages (module add8_core).
// ADD8_RR_SCHED_CARRY_OUT_EN adds the carry out of the top bit.
module add8_core
    import add8_sched_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADD8_RR_SCHED_CARRY_OUT_EN
    output logic             carry,
`endif
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] c;

    always_comb begin
        c    = '0;
        for (int i = 1; i < WIDTH; i++) begin
            c[i] = (a[i-1] & b[i-1]) | (c[i-1] & (a[i-1] ^ b[i-1]));
        end
        sum = a ^ b ^ c;
    end

`ifdef ADD8_RR_SCHED_CARRY_OUT_EN
    assign carry = (a[WIDTH-1] & b[WIDTH-1]) | (c[WIDTH-1] & (a[WIDTH-1] ^ b[WIDTH-1]));
`endif

endmodule

// File: rtl/add8_rr_sched.sv
// Round-robin scheduler sharing one adder among NUM_REQ requesters.
// ADD8_RR_SCHED_CARRY_OUT_EN adds a registered rsp_carry output.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally
// EXEC  | latched operands drive the adder; result registered at exit
// RESP  | result presented until rsp_ready
module add8_rr_sched
    import add8_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = ADD_WIDTH,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
`ifdef ADD8_RR_SCHED_CARRY_OUT_EN
    output logic                     rsp_carry,
`endif
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    state_t               state, state_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [WIDTH-1:0]     op_a, op_b;
    logic [ID_W-1:0]      op_id;
    logic [MAX_REQ-1:0]   valid_ext;
    pick_t                pick;
    logic [ID_W-1:0]      gnt_id;
    logic [WIDTH-1:0]     add_sum;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        pick                     = rr_pick(valid_ext, 4'(rr_ptr), NUM_REQ);
        gnt_id                   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick.idx == 4'(i)) gnt_id = ID_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    req_ready[gnt_id] = 1'b1;
                    state_nxt         = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

`ifdef ADD8_RR_SCHED_CARRY_OUT_EN
    logic add_carry;

    add8_core #(.WIDTH(WIDTH)) u_core (
        .a     (op_a),
        .b     (op_b),
        .carry (add_carry),
        .sum   (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst)                rsp_carry <= 1'b0;
        else if (state == EXEC) rsp_carry <= add_carry;
    end
`else
    add8_core #(.WIDTH(WIDTH)) u_core (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= '0;
            rsp_sum <= '0;
            rsp_id  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick.found) begin
                        op_a  <= req_a[gnt_id*WIDTH +: WIDTH];
                        op_b  <= req_b[gnt_id*WIDTH +: WIDTH];
                        op_id <= gnt_id;
                    end
                end
                EXEC: begin
                    rsp_sum <= add_sum;
                    rsp_id  <= op_id;
                end
                RESP: begin
                    // Priority rotates only once the response is consumed.
                    if (rsp_ready) begin
                        rr_ptr <= (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/add8_rr_sched.md
Name: add8_rr_sched

Overview:
- Round-robin scheduler that time-shares one combinational 8-bit modular adder (sum = a + b mod 256, no carry out) between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, latches its operands, drives the shared adder, registers the result, and returns it on a single response channel tagged with the requester ID.
- Sits between requester-side client logic and the adder core in FHE-benchmark datapaths.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, operand and sum width; must match the adder core (8).
- ID_W, $clog2(NUM_REQ), width of the requester ID tag; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester operand-pair valid.
- req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B; same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH.
- rsp_id  output  ID_W  index of the requester that issued this result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0;
  - rr_ptr=0, latched operands=0.
  - Reset mid-operation discards any in-flight op; no response is emitted for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, the winner g is the first set bit scanning rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle; the handshake completes at that edge.
  - At the edge: latch a=req_a[g], b=req_b[g], id=g; go to EXEC.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- EXEC:
  - Latched operands drive the adder core.
  - At the edge: rsp_sum <= adder output, rsp_id <= id; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id held stable until accepted.
  - When rsp_valid & rsp_ready: rr_ptr <= (id+1) mod NUM_REQ; go to IDLE; rsp_valid drops the next cycle.
  - req_ready=0 throughout RESP; there is no overlap with the next accept.
- Latency and throughput:
  - Accept edge to rsp_valid high: 2 cycles.
  - Minimum initiation interval: 3 cycles (accept, EXEC, RESP with rsp_ready=1).
- Fairness:
  - The pointer advances only on response completion, so a continuously asserted requester waits at most NUM_REQ-1 grants.
  - The pointer wraps from NUM_REQ-1 to 0.
- Arithmetic:
  - Sum is modulo 2^WIDTH; overflow silently wraps (0xFF+0x01=0x00).
- Requester rules:
  - A requester must keep its req_a/req_b stable while req_valid is high and not yet granted.
  - Deasserting req_valid before grant is permitted; the request is simply not served.
- Backpressure:
  - rsp_ready held low keeps the block in RESP indefinitely.
  - All req_ready stay 0 during that time.

Optional Feature:
- Macro: ADD8_RR_SCHED_CARRY_OUT_EN.
- When defined:
  - Extra output port rsp_carry (1 bit), registered alongside rsp_sum in EXEC.
  - rsp_carry equals bit WIDTH of the (WIDTH+1)-bit sum a+b; reset value 0.
  - The adder-core wrapper computes carry as the majority-chain carry of bit WIDTH-1.
- When undefined:
  - Port absent; behaviour is identical to the base description.

Decomposition:
- Shared package add8_sched_pkg holds:
  - state enum typedef (IDLE, EXEC, RESP);
  - ADD_WIDTH=8 constant;
  - function rr_pick(valid, ptr) returning the winning index plus a found flag.
- One sub-module: add8_core. It is a purely combinational 8-bit ripple XOR/AND adder with inputs a, b; output sum; and carry only under the macro. It is instantiated once.

Test Plan:
- Reset mid-op: req_valid[0]=1, a=0x12, b=0x34; assert rst during EXEC -> rsp_valid never rises; after release, busy=0 and rr_ptr=0.
- Single op: requester 2 issues a=0x3C, b=0x05 -> req_ready=4'b0100 in the issue cycle; 2 cycles later rsp_valid=1, rsp_sum=0x41, rsp_id=2.
- Wrap: a=0xFF, b=0x01 -> rsp_sum=0x00. With ADD8_RR_SCHED_CARRY_OUT_EN defined, rsp_carry=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each grant is 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_sum/rsp_id stable, all req_ready=0. Release -> return to IDLE and grant the next requester after rsp_id.
- Sparse requesters: rr_ptr=3, only req_valid[1] set -> grant 1 (scan wraps through 0); the next rr_ptr is 2.
